// File: rtl/tf_agen_pkg.sv
// Shared types and constants for the radix-4 twiddle address generator.
// Holds the FSM encoding, ROM geometry and the base-exponent helper.
package tf_agen_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam int TW_AW     = 4;
    localparam int ROM_DEPTH = 16;
    localparam int RADIX     = 4;
    localparam int NSTG_DEF  = 3;
    localparam int STG_W     = 2;
    localparam int BFY_W     = 4;

    // k = (bfy << 2*stg) mod 16; stage 2 and above always shift out to zero
    function automatic logic [TW_AW-1:0] base_exp(
        input logic [STG_W-1:0] stg,
        input logic [BFY_W-1:0] bfy
    );
        logic [TW_AW-1:0] k;
        k = '0;
        unique case (stg)
            2'd0:    k = bfy;
            2'd1:    k = {bfy[1:0], 2'b00};
            default: k = '0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/tf_cnt.sv
// Stage/butterfly counter for the twiddle address generator.
// Butterfly wraps 15->0 and bumps the stage; last flags the final set.
module tf_cnt
    import tf_agen_pkg::*;
#(
    parameter int NSTG = NSTG_DEF,
    parameter int NBFY = ROM_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    output logic [STG_W-1:0] stg,
    output logic [BFY_W-1:0] bfy,
    output logic             last
);

    logic bfy_wrap;

    assign bfy_wrap = (bfy == BFY_W'(NBFY - 1));
    assign last     = bfy_wrap && (stg == STG_W'(NSTG - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stg <= '0;
            bfy <= '0;
        end else if (clr || (en && last)) begin
            stg <= '0;
            bfy <= '0;
        end else if (en) begin
            bfy <= bfy_wrap ? '0 : bfy + 1'b1;
            if (bfy_wrap) begin
                stg <= stg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tf_agen.sv
// Twiddle ROM address generator for a radix-4 FFT: issues EXP1..3 per butterfly.
// FSM sequences a frame of NSTG*16 address sets; TVLD tracks ROM read latency.
module tf_agen
    import tf_agen_pkg::*;
#(
    parameter int NSTG = NSTG_DEF,
    parameter int NBFY = ROM_DEPTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             HOLD,
    output logic [TW_AW-1:0] EXP1,
    output logic [TW_AW-1:0] EXP2,
    output logic [TW_AW-1:0] EXP3,
    output logic             AVLD,
    output logic             TVLD,
    output logic [STG_W-1:0] STG,
    output logic [BFY_W-1:0] BFY,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state;
    state_t           nstate;
    logic             cnt_clr;
    logic             issue;
    logic             last;
    logic [STG_W-1:0] cstg;
    logic [BFY_W-1:0] cbfy;
    logic [TW_AW-1:0] k;
    logic [TW_AW-1:0] k2;

    // Busy covers the tail of the ROM pipeline, so restarts wait for it
    assign BUSY    = (state != S_IDLE) || AVLD || TVLD;
    assign cnt_clr = (state == S_IDLE) && START && !BUSY;
    assign issue   = (state == S_RUN) && !HOLD;

    assign k  = base_exp(cstg, cbfy);
    assign k2 = {k[TW_AW-2:0], 1'b0};

    tf_cnt #(
        .NSTG (NSTG),
        .NBFY (NBFY)
    ) u_cnt (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (cnt_clr),
        .en   (issue),
        .stg  (cstg),
        .bfy  (cbfy),
        .last (last)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:  if (cnt_clr) nstate = S_RUN;
            S_RUN:   if (issue && last) nstate = S_FIN;
            S_FIN:   nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            EXP1 <= '0;
            EXP2 <= '0;
            EXP3 <= '0;
            STG  <= '0;
            BFY  <= '0;
            AVLD <= 1'b0;
            TVLD <= 1'b0;
            DONE <= 1'b0;
        end else begin
            AVLD <= issue;
            TVLD <= AVLD;
            DONE <= (state == S_FIN);
            if (issue) begin
                EXP1 <= k;
                EXP2 <= k2;
                EXP3 <= k + k2;
                STG  <= cstg;
                BFY  <= cbfy;
            end
        end
    end

endmodule
